saes_decrypt_core: RTL and testbench



---
 rtl/saes_decrypt_core.sv | 210 +++++++++++++++++++++
 tb/tb_saes_decrypt_core.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saes_decrypt_core.sv
// Purpose : iterative 16-bit S-AES decryptor (ct + key in, pt out), round keys expanded in-core.
// Latency : out_valid rises 4 edges after the input transfer (2 on a key-cache hit).
// Backpress: pt/out_valid held until out_ready; in_ready is high only while idle.
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid/in_ready    input handshake; ct and key are sampled on transfer
//   ct[15:0], key[15:0]  ciphertext and cipher key K0
//   out_valid/out_ready  output handshake; pt is registered and stable while waiting
//   pt[15:0]             plaintext
//
// Optional feature: define SAES_KEY_CACHE_EN to skip key expansion when the key
// matches the key of the last completed expansion.

module saes_decrypt_core (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] ct,
   input  logic [15:0] key,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] pt
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_KX1  = 3'd1,
      S_KX2  = 3'd2,
      S_RND2 = 3'd3,
      S_RND1 = 3'd4,
      S_OUT  = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] st_q, st_d;
   logic [15:0] k0_q, k0_d;
   logic [15:0] k1_q, k1_d;
   logic [15:0] k2_q, k2_d;
   logic [15:0] pt_q, pt_d;
   logic        out_valid_q, out_valid_d;
   logic        cache_hit;

   // ---------------------------------------------------------------------
   // S-AES primitives
   // ---------------------------------------------------------------------
   function automatic logic [3:0] sbox(input logic [3:0] n);
      logic [3:0] r;
      case (n)
         4'h0: r = 4'h9;  4'h1: r = 4'h4;  4'h2: r = 4'hA;  4'h3: r = 4'hB;
         4'h4: r = 4'hD;  4'h5: r = 4'h1;  4'h6: r = 4'h8;  4'h7: r = 4'h5;
         4'h8: r = 4'h6;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'h3;
         4'hC: r = 4'hC;  4'hD: r = 4'hE;  4'hE: r = 4'hF;  default: r = 4'h7;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] n);
      logic [3:0] r;
      case (n)
         4'h0: r = 4'hA;  4'h1: r = 4'h5;  4'h2: r = 4'h9;  4'h3: r = 4'hB;
         4'h4: r = 4'h1;  4'h5: r = 4'h7;  4'h6: r = 4'h8;  4'h7: r = 4'hF;
         4'h8: r = 4'h6;  4'h9: r = 4'h0;  4'hA: r = 4'h2;  4'hB: r = 4'h3;
         4'hC: r = 4'hC;  4'hD: r = 4'h4;  4'hE: r = 4'hD;  default: r = 4'hE;
      endcase
      return r;
   endfunction

   // Multiply by x in GF(2^4) mod x^4+x+1: the dropped x^4 folds back as x+1.
   function automatic logic [3:0] gf_mul2(input logic [3:0] x);
      return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
   endfunction

   function automatic logic [3:0] gf_mul9(input logic [3:0] x);
      return gf_mul2(gf_mul2(gf_mul2(x))) ^ x;
   endfunction

   // One key-schedule step: {w_even, w_odd} from the previous word pair.
   // The g-function rotates the nibbles of the odd word before substitution.
   function automatic logic [15:0] key_step(input logic [15:0] prev, input logic [7:0] rcon);
      logic [7:0] w_even;
      logic [7:0] w_odd;
      w_even = prev[15:8] ^ rcon ^ {sbox(prev[3:0]), sbox(prev[7:4])};
      w_odd  = w_even ^ prev[7:0];
      return {w_even, w_odd};
   endfunction

   function automatic logic [15:0] inv_shift_rows(input logic [15:0] s);
      return {s[15:12], s[3:0], s[7:4], s[11:8]};
   endfunction

   function automatic logic [15:0] inv_sub(input logic [15:0] s);
      return {inv_sbox(s[15:12]), inv_sbox(s[11:8]), inv_sbox(s[7:4]), inv_sbox(s[3:0])};
   endfunction

   function automatic logic [15:0] inv_mix(input logic [15:0] s);
      return {gf_mul9(s[15:12]) ^ gf_mul2(s[11:8]),
              gf_mul2(s[15:12]) ^ gf_mul9(s[11:8]),
              gf_mul9(s[7:4])   ^ gf_mul2(s[3:0]),
              gf_mul2(s[7:4])   ^ gf_mul9(s[3:0])};
   endfunction

   // ---------------------------------------------------------------------
   // Optional key cache
   // ---------------------------------------------------------------------
`ifdef SAES_KEY_CACHE_EN
   logic        cache_vld_q, cache_vld_d;
   logic [15:0] cache_key_q, cache_key_d;

   // k0 is stable across the whole expansion, so it is the key K1/K2 belong to.
   always_comb begin
      cache_vld_d = cache_vld_q;
      cache_key_d = cache_key_q;
      if (state_q == S_KX2) begin
         cache_vld_d = 1'b1;
         cache_key_d = k0_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cache_vld_q <= 1'b0;
         cache_key_q <= 16'h0000;
      end else begin
         cache_vld_q <= cache_vld_d;
         cache_key_q <= cache_key_d;
      end
   end

   assign cache_hit = cache_vld_q && (key == cache_key_q);
`else
   assign cache_hit = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // FSM: next state and datapath
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      st_d        = st_q;
      k0_d        = k0_q;
      k1_d        = k1_q;
      k2_d        = k2_q;
      pt_d        = pt_q;
      out_valid_d = out_valid_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               st_d    = ct;
               k0_d    = key;
               state_d = cache_hit ? S_RND2 : S_KX1;
            end
         end
         S_KX1: begin
            k1_d    = key_step(k0_q, 8'h80);
            state_d = S_KX2;
         end
         S_KX2: begin
            k2_d    = key_step(k1_q, 8'h30);
            state_d = S_RND2;
         end
         S_RND2: begin
            st_d    = inv_sub(inv_shift_rows(st_q ^ k2_q));
            state_d = S_RND1;
         end
         S_RND1: begin
            pt_d        = inv_sub(inv_shift_rows(inv_mix(st_q ^ k1_q))) ^ k0_q;
            out_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         st_q        <= 16'h0000;
         k0_q        <= 16'h0000;
         k1_q        <= 16'h0000;
         k2_q        <= 16'h0000;
         pt_q        <= 16'h0000;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         st_q        <= st_d;
         k0_q        <= k0_d;
         k1_q        <= k1_d;
         k2_q        <= k2_d;
         pt_q        <= pt_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign pt        = pt_q;

endmodule

// File: tb/tb_saes_decrypt_core.sv
module tb_saes_decrypt_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] ct;
   logic [15:0] key;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] pt;

   int vectors     = 0;
   int miscompares = 0;

   // expectation of the key cache, tracked from transfers and resets
   bit          model_cache_vld = 1'b0;
   logic [15:0] model_cache_key = 16'h0000;

   saes_decrypt_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ct        (ct),
      .key       (key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .pt        (pt)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Reference model: textbook S-AES on nibble arrays, generic GF mult
   // ------------------------------------------------------------------
   function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
      logic [3:0] r = 4'h0;
      logic [3:0] x = a;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) r = r ^ x;
         x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
      end
      return r;
   endfunction

   function automatic logic [3:0] fsb(input logic [3:0] x);
      logic [3:0] tbl [16];
      tbl = '{4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
              4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7};
      return tbl[x];
   endfunction

   // inverse S-box found by searching the forward table
   function automatic logic [3:0] isb(input logic [3:0] y);
      logic [3:0] r = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (fsb(i[3:0]) == y) r = i[3:0];
      end
      return r;
   endfunction

   function automatic logic [31:0] expand(input logic [15:0] k);
      logic [7:0] w [6];
      logic [7:0] rot;
      logic [7:0] rc;
      w[0] = k[15:8];
      w[1] = k[7:0];
      for (int r = 0; r < 2; r++) begin
         rc = (r == 0) ? 8'h80 : 8'h30;
         rot = {w[2*r+1][3:0], w[2*r+1][7:4]};
         w[2*r+2] = w[2*r] ^ rc ^ {fsb(rot[7:4]), fsb(rot[3:0])};
         w[2*r+3] = w[2*r+2] ^ w[2*r+1];
      end
      return {w[2], w[3], w[4], w[5]};
   endfunction

   function automatic logic [15:0] subw(input logic [15:0] v, input bit inv);
      logic [15:0] o;
      for (int i = 0; i < 4; i++) begin
         o[4*i +: 4] = inv ? isb(v[4*i +: 4]) : fsb(v[4*i +: 4]);
      end
      return o;
   endfunction

   function automatic logic [15:0] shiftw(input logic [15:0] v);
      logic [3:0] s [4];
      for (int i = 0; i < 4; i++) s[i] = v[15-4*i -: 4];
      return {s[0], s[3], s[2], s[1]};
   endfunction

   // column (a,b) -> (d*a ^ o*b, o*a ^ d*b)
   function automatic logic [15:0] mixw(input logic [15:0] v, input logic [3:0] d, input logic [3:0] o);
      logic [3:0] s [4];
      logic [3:0] t [4];
      for (int i = 0; i < 4; i++) s[i] = v[15-4*i -: 4];
      for (int c = 0; c < 2; c++) begin
         t[2*c]   = gmul(d, s[2*c]) ^ gmul(o, s[2*c+1]);
         t[2*c+1] = gmul(o, s[2*c]) ^ gmul(d, s[2*c+1]);
      end
      return {t[0], t[1], t[2], t[3]};
   endfunction

   function automatic logic [15:0] ref_enc(input logic [15:0] p, input logic [15:0] k);
      logic [31:0] ks = expand(k);
      logic [15:0] v;
      v = p ^ k;
      v = mixw(shiftw(subw(v, 1'b0)), 4'h1, 4'h4) ^ ks[31:16];
      v = shiftw(subw(v, 1'b0)) ^ ks[15:0];
      return v;
   endfunction

   function automatic logic [15:0] ref_dec(input logic [15:0] c, input logic [15:0] k);
      logic [31:0] ks = expand(k);
      logic [15:0] v;
      v = subw(shiftw(c ^ ks[15:0]), 1'b1);
      v = subw(shiftw(mixw(v ^ ks[31:16], 4'h9, 4'h2)), 1'b1);
      return v ^ k;
   endfunction

   // ------------------------------------------------------------------
   // Checking and stimulus helpers
   // ------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Hands one block to the DUT; returns at the first negedge after the
   // transfer edge, with the latency the cache model predicts.
   task automatic issue(input logic [15:0] c, input logic [15:0] k, output int lat_exp);
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before_issue", in_ready, 1'b1);
`ifdef SAES_KEY_CACHE_EN
      lat_exp = (model_cache_vld && k == model_cache_key) ? 2 : 4;
`else
      lat_exp = 4;
`endif
      in_valid = 1'b1;
      ct       = c;
      key      = k;
      @(posedge clk);
      model_cache_vld = 1'b1;
      model_cache_key = k;
      @(negedge clk);
      in_valid = 1'b0;
      ct       = 16'($urandom);
      key      = 16'($urandom);
   endtask

   // Called at the negedge following edge T; lat = edges after T at which out_valid is seen.
   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic do_block(input logic [15:0] c, input logic [15:0] k, input logic [15:0] exp_pt,
                           input string tag);
      int le;
      int lat;
      issue(c, k, le);
      wait_out(lat);
      check({tag, "_latency"}, lat, le);
      check({tag, "_pt"}, pt, exp_pt);
      @(negedge clk);
      check({tag, "_pulse_end"}, out_valid, 1'b0);
   endtask

   // ------------------------------------------------------------------
   // Directed and random sequence
   // ------------------------------------------------------------------
   initial begin
      int          le;
      int          lat;
      int          pulses;
      logic [15:0] p;
      logic [15:0] k;
      logic [15:0] last_k;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      ct        = 16'h0000;
      key       = 16'h0000;
      out_ready = 1'b1;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_pt", pt, 16'h0000);
      rst_n = 1'b1;
      model_cache_vld = 1'b0;
      @(negedge clk);
      check("reset_in_ready", in_ready, 1'b1);

      // known-answer vector
      do_block(16'h0738, 16'hA73B, 16'h6F6B, "kat");
      check("kat_in_ready_after", in_ready, 1'b1);

      // backpressure: hold output for 10 cycles
      out_ready = 1'b0;
      issue(16'h0738, 16'hA73B, le);
      wait_out(lat);
      check("bp_latency", lat, le);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold_valid", out_valid, 1'b1);
         check("bp_hold_pt", pt, 16'h6F6B);
         check("bp_hold_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", out_valid, 1'b0);
      check("bp_release_in_ready", in_ready, 1'b1);

      // all-zero block
      do_block(16'h0000, 16'h0000, ref_dec(16'h0000, 16'h0000), "zero");

      // reset while in RND2 aborts the block
      issue(16'h1234, 16'h5555, le);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_pt", pt, 16'h0000);
      rst_n = 1'b1;
      model_cache_vld = 1'b0;
      @(negedge clk);
      check("abort_in_ready", in_ready, 1'b1);
      do_block(16'h0738, 16'hA73B, 16'h6F6B, "after_abort");

      // same key again (cache hit when enabled), then a new key
      do_block(16'h0738, 16'hA73B, 16'h6F6B, "repeat_key");
      do_block(16'h0738, 16'h0000, ref_dec(16'h0738, 16'h0000), "new_key");

      // in_valid held high with changing ct while busy: one capture only
      p = 16'h3C5A;
      k = 16'hBEEF;
      @(negedge clk);
`ifdef SAES_KEY_CACHE_EN
      le = (model_cache_vld && k == model_cache_key) ? 2 : 4;
`else
      le = 4;
`endif
      in_valid = 1'b1;
      ct       = ref_enc(p, k);
      key      = k;
      @(posedge clk);
      model_cache_vld = 1'b1;
      model_cache_key = k;
      @(negedge clk);
      lat = 0;
      while (!out_valid && lat < 20) begin
         ct = 16'($urandom);
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      check("busy_latency", lat, le);
      check("busy_pt", pt, p);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      check("busy_extra_outputs", pulses, 0);

      // random round trips, with occasional key reuse
      last_k = k;
      for (int n = 0; n < 1000; n++) begin
         p = 16'($urandom);
         k = ($urandom_range(0, 3) == 0) ? last_k : 16'($urandom);
         do_block(ref_enc(p, k), k, p, "rand");
         last_k = k;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
